// File: rtl/bomb_pkg.sv
// Shared tile codes, slot state encoding and tile-index helpers for the bomb controller.
package bomb_pkg;

  localparam int MAP_COLS_DEF = 20;
  localparam int MAP_ROWS_DEF = 15;

  localparam logic [9:0] NO_TILE     = 10'h3FF;
  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_BRICK  = 4'd2;
  localparam logic [3:0] TILE_PORTAL = 4'd3;
  localparam logic [3:0] TILE_LIVES  = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_BLAST} slot_state_e;

  // Sprite top-left pixel to the tile column/row holding the sprite centre.
  function automatic logic [9:0] tile_col(input logic [9:0] x);
    logic [9:0] cx;
    cx = x + 10'd10;
    return cx >> 5;
  endfunction

  function automatic logic [9:0] tile_row(input logic [9:0] y);
    logic [9:0] cy;
    cy = y + 10'd13;
    return cy >> 5;
  endfunction

  function automatic logic [9:0] tile_index(input logic [9:0] row, input logic [9:0] col,
                                            input int cols);
    return 10'(row * 10'(cols) + col);
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: arm on a fresh drop, burn the fuse, scan the four neighbours,
// hold the blast and clear any bricks it reached.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int MAP_COLS     = MAP_COLS_DEF,
  parameter int MAP_ROWS     = MAP_ROWS_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_tick,
  input  logic            drop_edge,
  input  logic [9:0]      drop_row,
  input  logic [9:0]      drop_col,
  input  logic [9:0]      other_center,
  input  logic            other_armed,
  input  logic            force_scan,
  output logic            rd_req,
  output logic [9:0]      rd_tile,
  input  logic            rd_gnt,
  input  logic [3:0]      rd_data,
  output logic            wr_req,
  output logic [9:0]      wr_tile,
  input  logic            wr_gnt,
  output slot_state_e     state,
  output logic [9:0]      center,
  output logic [4:0][9:0] die
);

  slot_state_e      state_nxt;
  logic [9:0]       center_nxt, row, row_nxt, col, col_nxt, drop_tile, nb_tile;
  logic [15:0]      frame_cnt, cnt_nxt;
  logic [2:0]       req_idx, req_idx_nxt, pend_idx, pend_idx_nxt, sel;
  logic             pend_valid, pend_valid_nxt, nb_off, enter_scan;
  logic [4:0][9:0]  scan_tiles, tiles_nxt, die_nxt;
  logic [4:0]       brick_mask, mask_nxt;

  assign drop_tile = tile_index(drop_row, drop_col, MAP_COLS);

  // Neighbour currently being requested; edge neighbours are skipped without a read.
  always_comb begin
    nb_tile = center;
    nb_off  = 1'b0;
    case (req_idx)
      3'd1: begin nb_tile = center - 10'(MAP_COLS); nb_off = (row == 10'd0); end
      3'd2: begin nb_tile = center + 10'(MAP_COLS); nb_off = (row == 10'(MAP_ROWS - 1)); end
      3'd3: begin nb_tile = center - 10'd1;         nb_off = (col == 10'd0); end
      3'd4: begin nb_tile = center + 10'd1;         nb_off = (col == 10'(MAP_COLS - 1)); end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    center_nxt     = center;
    row_nxt        = row;
    col_nxt        = col;
    cnt_nxt        = frame_cnt;
    req_idx_nxt    = req_idx;
    pend_valid_nxt = 1'b0;
    pend_idx_nxt   = pend_idx;
    tiles_nxt      = scan_tiles;
    mask_nxt       = brick_mask;
    die_nxt        = die;
    enter_scan     = 1'b0;
    sel            = 3'd1;
    rd_req         = 1'b0;
    rd_tile        = nb_tile;
    wr_req         = 1'b0;
    wr_tile        = 10'd0;

    // Data for the read issued last cycle: walls stop the blast, bricks get cleared.
    if (pend_valid) begin
      if (rd_data == TILE_WALL) tiles_nxt[pend_idx] = NO_TILE;
      else if (rd_data == TILE_BRICK) mask_nxt[pend_idx] = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (frame_tick && drop_edge && !(other_armed && other_center == drop_tile)) begin
          state_nxt  = S_ARMED;
          center_nxt = drop_tile;
          row_nxt    = drop_row;
          col_nxt    = drop_col;
          cnt_nxt    = 16'(FUSE_FRAMES - 1);
        end
      end
      S_ARMED: begin
        if (force_scan || (frame_tick && frame_cnt == 16'd0)) enter_scan = 1'b1;
        else if (frame_tick) cnt_nxt = frame_cnt - 16'd1;
      end
      S_SCAN: begin
        if (req_idx <= 3'd4) begin
          if (nb_off) begin
            tiles_nxt[req_idx] = NO_TILE;
            req_idx_nxt        = req_idx + 3'd1;
          end else begin
            rd_req = 1'b1;
            if (rd_gnt) begin
              tiles_nxt[req_idx] = nb_tile;
              pend_valid_nxt     = 1'b1;
              pend_idx_nxt       = req_idx;
              req_idx_nxt        = req_idx + 3'd1;
            end
          end
        end else begin
          state_nxt = S_BLAST;
          die_nxt   = tiles_nxt;
          cnt_nxt   = 16'(BLAST_FRAMES);
        end
      end
      S_BLAST: begin
        if (frame_tick && frame_cnt != 16'd0) cnt_nxt = frame_cnt - 16'd1;
        // Bricks drain lowest index first; the slot only retires once all are written.
        if (|brick_mask) begin
          for (int k = 4; k >= 1; k--) if (brick_mask[k]) sel = 3'(k);
          wr_req  = 1'b1;
          wr_tile = scan_tiles[sel];
          if (wr_gnt) mask_nxt[sel] = 1'b0;
        end else if (frame_cnt == 16'd0) begin
          state_nxt = S_IDLE;
          die_nxt   = {5{NO_TILE}};
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (enter_scan) begin
      state_nxt    = S_SCAN;
      req_idx_nxt  = 3'd1;
      tiles_nxt    = {5{NO_TILE}};
      tiles_nxt[0] = center;
      mask_nxt     = 5'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      center     <= NO_TILE;
      row        <= 10'd0;
      col        <= 10'd0;
      frame_cnt  <= 16'd0;
      req_idx    <= 3'd0;
      pend_valid <= 1'b0;
      pend_idx   <= 3'd0;
      scan_tiles <= {5{NO_TILE}};
      brick_mask <= 5'd0;
      die        <= {5{NO_TILE}};
    end else begin
      state      <= state_nxt;
      center     <= center_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      frame_cnt  <= cnt_nxt;
      req_idx    <= req_idx_nxt;
      pend_valid <= pend_valid_nxt;
      pend_idx   <= pend_idx_nxt;
      scan_tiles <= tiles_nxt;
      brick_mask <= mask_nxt;
      die        <= die_nxt;
    end
  end

endmodule

// File: rtl/bomb_blast_ctrl.sv
// Two-player bomb controller: frame_clk synchronizer, two bomb slots, shared map read/write ports.
// Define CHAIN_BLAST_EN to let a blast immediately detonate the other player's armed bomb.
module bomb_blast_ctrl
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int MAP_COLS     = MAP_COLS_DEF,
  parameter int MAP_ROWS     = MAP_ROWS_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  input  logic [1:0]      drop,
  input  logic [9:0]      user1X,
  input  logic [9:0]      user1Y,
  input  logic [9:0]      user2X,
  input  logic [9:0]      user2Y,
  output logic [9:0]      rd_addr,
  input  logic [3:0]      rd_data,
  output logic [9:0]      ram_addr,
  output logic [3:0]      ram_data,
  output logic            ram_en,
  output logic [9:0][9:0] die_addr,
  output logic [1:0][9:0] bomb_addr,
  output logic [1:0]      bomb_active,
  output logic [1:0]      blast_active
);

  logic [2:0]            frame_sync;
  logic                  frame_tick;
  logic [1:0]            drop_prev, rd_req, rd_gnt, wr_req, wr_gnt, force_scan;
  logic [1:0][9:0]       drop_row, drop_col, rd_tile, wr_tile, slot_center;
  logic [1:0][4:0][9:0]  slot_die;
  slot_state_e           slot_state [2];

  // frame_clk is asynchronous; two flops resynchronize, the third finds the rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync <= 3'd0;
      drop_prev  <= 2'd0;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      if (frame_tick) drop_prev <= drop;
    end
  end

  assign frame_tick  = frame_sync[1] & ~frame_sync[2];
  assign drop_row[0] = tile_row(user1Y);
  assign drop_col[0] = tile_col(user1X);
  assign drop_row[1] = tile_row(user2Y);
  assign drop_col[1] = tile_col(user2X);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    bomb_slot #(
      .FUSE_FRAMES (FUSE_FRAMES),
      .BLAST_FRAMES(BLAST_FRAMES),
      .MAP_COLS    (MAP_COLS),
      .MAP_ROWS    (MAP_ROWS)
    ) u_slot (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_tick  (frame_tick),
      .drop_edge   (drop[g] & ~drop_prev[g]),
      .drop_row    (drop_row[g]),
      .drop_col    (drop_col[g]),
      .other_center(slot_center[1-g]),
      .other_armed (bomb_active[1-g]),
      .force_scan  (force_scan[g]),
      .rd_req      (rd_req[g]),
      .rd_tile     (rd_tile[g]),
      .rd_gnt      (rd_gnt[g]),
      .rd_data     (rd_data),
      .wr_req      (wr_req[g]),
      .wr_tile     (wr_tile[g]),
      .wr_gnt      (wr_gnt[g]),
      .state       (slot_state[g]),
      .center      (slot_center[g]),
      .die         (slot_die[g])
    );

    assign bomb_active[g]  = (slot_state[g] == S_ARMED);
    assign blast_active[g] = (slot_state[g] == S_BLAST);
    assign bomb_addr[g]    = bomb_active[g] ? slot_center[g] : NO_TILE;
  end

  assign die_addr = slot_die;

`ifdef CHAIN_BLAST_EN
  // A published blast covering the other armed bomb sends that bomb straight to SCAN.
  always_comb begin
    force_scan = 2'b00;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 5; k++)
        if (slot_state[i] == S_BLAST && slot_state[1-i] == S_ARMED &&
            slot_die[i][k] == slot_center[1-i])
          force_scan[1-i] = 1'b1;
  end
`else
  assign force_scan = 2'b00;
`endif

  // Fixed priority on both map ports: slot 0 wins, slot 1 simply retries.
  always_comb begin
    rd_gnt   = 2'b00;
    wr_gnt   = 2'b00;
    rd_addr  = 10'd0;
    ram_addr = 10'd0;
    if (rd_req[0]) begin
      rd_gnt[0] = 1'b1;
      rd_addr   = rd_tile[0];
    end else if (rd_req[1]) begin
      rd_gnt[1] = 1'b1;
      rd_addr   = rd_tile[1];
    end
    if (wr_req[0]) begin
      wr_gnt[0] = 1'b1;
      ram_addr  = wr_tile[0];
    end else if (wr_req[1]) begin
      wr_gnt[1] = 1'b1;
      ram_addr  = wr_tile[1];
    end
  end

  assign ram_en   = |wr_gnt;
  assign ram_data = TILE_EMPTY;

endmodule

// File: tb/tb_bomb_blast_ctrl.sv
// Directed bench for bomb_blast_ctrl with a behavioural map RAM and a write logger.
module tb_bomb_blast_ctrl;

  localparam logic [9:0] NT = 10'h3FF;

  logic            Clk = 1'b0;
  logic            Reset_n, frame_clk;
  logic [1:0]      drop;
  logic [9:0]      user1X, user1Y, user2X, user2Y;
  logic [9:0]      rd_addr, ram_addr;
  logic [3:0]      rd_data, ram_data;
  logic            ram_en;
  logic [9:0][9:0] die_addr;
  logic [1:0][9:0] bomb_addr;
  logic [1:0]      bomb_active, blast_active;

  logic [3:0] map_mem [1024];
  logic [9:0] wr_log [$];
  int checks = 0, failures = 0, wr_bad_data = 0;
  int rd_bad_cnt = 0, rd_20_cnt = 0, rd_1_cnt = 0;
  int base, b_bad, b_20, b_1;
  logic got;

  bomb_blast_ctrl #(.FUSE_FRAMES(4), .BLAST_FRAMES(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .drop(drop),
    .user1X(user1X), .user1Y(user1Y), .user2X(user2X), .user2Y(user2Y),
    .rd_addr(rd_addr), .rd_data(rd_data), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_en(ram_en), .die_addr(die_addr), .bomb_addr(bomb_addr),
    .bomb_active(bomb_active), .blast_active(blast_active)
  );

  always #5 Clk = ~Clk;

  // Map RAM with one cycle read latency, plus logs of reads and writes.
  always @(posedge Clk) begin
    rd_data <= map_mem[rd_addr];
    if (rd_addr == 10'h3EC || rd_addr == 10'h3FF) rd_bad_cnt++;
    if (rd_addr == 10'd20) rd_20_cnt++;
    if (rd_addr == 10'd1) rd_1_cnt++;
    if (ram_en) begin
      wr_log.push_back(ram_addr);
      if (ram_data !== 4'd0) wr_bad_data++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkSlot(input string tag, input int g, input logic [4:0][9:0] exp);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("%s[%0d]", tag, 5*g + k), 32'(die_addr[5*g + k]), 32'(exp[k]));
  endtask

  // One full frame_clk period with the given drop value held across it.
  task automatic applyStimulus(input logic [1:0] drop_val);
    drop = drop_val;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    drop = 2'b00;
  endtask

  task automatic clearMap();
    for (int i = 0; i < 1024; i++) map_mem[i] = 4'd0;
  endtask

  initial begin
    Reset_n = 1'b1; frame_clk = 1'b0; drop = 2'b00;
    user1X = 10'd0; user1Y = 10'd0; user2X = 10'd0; user2Y = 10'd0;
    clearMap();
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);

    checkOutput("rst_die0", die_addr[0], NT);
    checkOutput("rst_die9", die_addr[9], NT);
    checkOutput("rst_bomb_addr0", bomb_addr[0], NT);
    checkOutput("rst_bomb_addr1", bomb_addr[1], NT);
    checkOutput("rst_bomb_active", bomb_active, 2'b00);
    checkOutput("rst_blast_active", blast_active, 2'b00);
    checkOutput("rst_ram_en", ram_en, 1'b0);
    checkOutput("rst_ram_data", ram_data, 4'd0);
    checkOutput("rst_rd_addr", rd_addr, 10'd0);
    checkOutput("rst_ram_addr", ram_addr, 10'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    $display("[TB] open map blast at tile 63");
    user1X = 10'd100; user1Y = 10'd100; user2X = 10'd100; user2Y = 10'd100;
    applyStimulus(2'b01);
    checkOutput("t1_bomb_addr0", bomb_addr[0], 10'd63);
    checkOutput("t1_bomb_active", bomb_active, 2'b01);
    applyStimulus(2'b10);
    checkOutput("t1_same_tile_reject", bomb_active, 2'b01);
    applyStimulus(2'b00);
    applyStimulus(2'b00);
    checkOutput("t1_still_armed", bomb_active, 2'b01);
    base = wr_log.size();
    applyStimulus(2'b00);
    repeat (20) @(negedge Clk);
    checkSlot("t1_die", 0, {10'd64, 10'd62, 10'd83, 10'd43, 10'd63});
    checkOutput("t1_slot1_die", die_addr[5], NT);
    checkOutput("t1_blast_active", blast_active, 2'b01);
    applyStimulus(2'b00);
    applyStimulus(2'b00);
    checkOutput("t1_hold", die_addr[0], 10'd63);
    applyStimulus(2'b00);
    repeat (4) @(negedge Clk);
    checkSlot("t1_clear", 0, {5{NT}});
    checkOutput("t1_blast_done", blast_active, 2'b00);
    checkOutput("t1_no_writes", wr_log.size() - base, 0);

    $display("[TB] wall above, brick to the right");
    map_mem[43] = 4'd1; map_mem[64] = 4'd2;
    applyStimulus(2'b01);
    repeat (3) applyStimulus(2'b00);
    base = wr_log.size();
    applyStimulus(2'b00);
    repeat (20) @(negedge Clk);
    checkSlot("t2_die", 0, {10'd64, 10'd62, 10'd83, NT, 10'd63});
    checkOutput("t2_write_count", wr_log.size() - base, 1);
    checkOutput("t2_write_addr", wr_log[base], 10'd64);
    checkOutput("t2_write_data_bad", wr_bad_data, 0);
    repeat (3) applyStimulus(2'b00);
    repeat (4) @(negedge Clk);

    $display("[TB] corner bomb at tile 0");
    clearMap();
    user1X = 10'd0; user1Y = 10'd0;
    applyStimulus(2'b01);
    checkOutput("t3_bomb_addr0", bomb_addr[0], 10'd0);
    repeat (3) applyStimulus(2'b00);
    b_bad = rd_bad_cnt; b_20 = rd_20_cnt; b_1 = rd_1_cnt;
    applyStimulus(2'b00);
    repeat (20) @(negedge Clk);
    checkSlot("t3_die", 0, {10'd1, NT, 10'd20, NT, 10'd0});
    checkOutput("t3_offmap_reads", rd_bad_cnt - b_bad, 0);
    checkOutput("t3_read_down", (rd_20_cnt - b_20) > 0, 1'b1);
    checkOutput("t3_read_right", (rd_1_cnt - b_1) > 0, 1'b1);
    repeat (3) applyStimulus(2'b00);
    repeat (4) @(negedge Clk);

    $display("[TB] both players drop together");
    clearMap();
    map_mem[43] = 4'd2; map_mem[83] = 4'd2; map_mem[109] = 4'd2; map_mem[130] = 4'd2;
    user1X = 10'd100; user1Y = 10'd100; user2X = 10'd300; user2Y = 10'd200;
    applyStimulus(2'b11);
    checkOutput("t4_bomb_addr1", bomb_addr[1], 10'd129);
    repeat (3) applyStimulus(2'b00);
    base = wr_log.size();
    applyStimulus(2'b00);
    repeat (25) @(negedge Clk);
    checkSlot("t4_die", 0, {10'd64, 10'd62, 10'd83, 10'd43, 10'd63});
    checkSlot("t4_die", 1, {10'd130, 10'd128, 10'd149, 10'd109, 10'd129});
    checkOutput("t4_write_count", wr_log.size() - base, 4);
    checkOutput("t4_write0", wr_log[base], 10'd43);
    checkOutput("t4_write1", wr_log[base+1], 10'd83);
    checkOutput("t4_write2", wr_log[base+2], 10'd109);
    checkOutput("t4_write3", wr_log[base+3], 10'd130);
    checkOutput("t4_write_data_bad", wr_bad_data, 0);
    repeat (3) applyStimulus(2'b00);
    repeat (4) @(negedge Clk);
    checkOutput("t4_blast_done", blast_active, 2'b00);

    $display("[TB] reset during brick clearing");
    clearMap();
    map_mem[43] = 4'd2; map_mem[83] = 4'd2; map_mem[64] = 4'd2;
    applyStimulus(2'b01);
    repeat (3) applyStimulus(2'b00);
    @(negedge Clk) frame_clk = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (ram_en) got = 1'b1;
    end
    checkOutput("t5_write_seen", got, 1'b1);
    Reset_n = 1'b0;
    #1;
    checkOutput("t5_ram_en", ram_en, 1'b0);
    checkOutput("t5_blast_active", blast_active, 2'b00);
    checkSlot("t5_die", 0, {5{NT}});
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    base = wr_log.size();
    repeat (40) @(negedge Clk);
    checkOutput("t5_no_late_writes", wr_log.size() - base, 0);
    checkOutput("t5_idle_after", blast_active | bomb_active, 2'b00);

    $display("[TB] blast reaching the other armed bomb");
    clearMap();
    user1X = 10'd100; user1Y = 10'd100; user2X = 10'd118; user2Y = 10'd100;
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    checkOutput("t6_both_armed", bomb_active, 2'b11);
    checkOutput("t6_bomb_addr1", bomb_addr[1], 10'd64);
    repeat (3) applyStimulus(2'b00);
    repeat (20) @(negedge Clk);
    checkOutput("t6_die4", die_addr[4], 10'd64);
`ifdef CHAIN_BLAST_EN
    checkOutput("t6_blast_active", blast_active, 2'b11);
    checkOutput("t6_bomb_active", bomb_active, 2'b00);
    checkOutput("t6_die5", die_addr[5], 10'd64);
`else
    checkOutput("t6_blast_active", blast_active, 2'b01);
    checkOutput("t6_bomb_active", bomb_active, 2'b10);
    checkOutput("t6_die5", die_addr[5], NT);
`endif
    repeat (5) applyStimulus(2'b00);
    repeat (20) @(negedge Clk);
    checkOutput("t6_all_idle", blast_active | bomb_active, 2'b00);
    checkOutput("t6_die9", die_addr[9], NT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bomb_blast_ctrl.md
Name: bomb_blast_ctrl

Overview:
- Owns bomb lifecycle for both players: accepts drop requests, runs fuses, scans the tile map around each bomb, and publishes blast tiles on die_addr[10], which the player controllers compare against their corner tiles.
- Acts as the map writer: bricks destroyed by a blast are cleared to empty through the map write port that the player controllers' map copies listen on.
- Sits between the two user controllers and the map RAMs.

Parameters:
- FUSE_FRAMES, 120, frame ticks from drop to detonation.
- BLAST_FRAMES, 30, frame ticks that die_addr stays valid.
- MAP_COLS, 20, tiles per row (32-px tiles).
- MAP_ROWS, 15, tile rows.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous reset, active-low
- frame_clk  in  1  vsync-rate strobe, asynchronous to Clk
- drop  in  2  bomb_drop from user1 [0] and user2 [1]
- user1X, user1Y, user2X, user2Y  in  10 each  sprite top-left pixel positions
- rd_addr  out  10  map read address
- rd_data  in  4  map tile code, 1-cycle latency
- ram_addr  out  10  map write address
- ram_data  out  4  map write data
- ram_en  out  1  map write enable
- die_addr  out  10x10  blast tiles; slot0 uses [0..4], slot1 uses [5..9]
- bomb_addr  out  2x10  armed bomb center tile per slot, for the renderer
- bomb_active  out  2  slot in ARMED
- blast_active  out  2  slot in BLAST

Behaviour:
- Tile codes: 0 empty, 1 hard wall, 2 brick, 3 portal, 4 lives power-up. NO_TILE = 10'h3FF; 300 and above are never valid tiles.
- frame_clk passes through a 2-FF synchronizer and a rising-edge detector to give frame_tick, one Clk wide. All frame counts use frame_tick.
- Reset, asynchronous and active-low:
  - all slots IDLE; die_addr[*] = NO_TILE; bomb_addr = NO_TILE; bomb_active = 0; blast_active = 0.
  - ram_en = 0; ram_data = 0; rd_addr = 0; ram_addr = 0.
  - The same applies mid-operation: no pending write completes.
- Bomb center tile = ((Y+13)>>5)*MAP_COLS + ((X+10)>>5), using the 10-bit sprite centre.
- Per-slot FSM:
  - IDLE -> ARMED: on frame_tick when drop[i]=1 and drop[i] was 0 at the previous frame_tick. The center is latched. The drop is rejected if it equals the other slot's armed center.
  - ARMED: the fuse counter counts down from FUSE_FRAMES-1 on each frame_tick. At 0 -> SCAN.
  - SCAN: requests the up, down, left and right tiles on rd_addr, one per Clk, and captures rd_data one cycle later. A neighbour off the map edge (row 0 up, row MAP_ROWS-1 down, col 0 left, col MAP_COLS-1 right) is not read and becomes NO_TILE.
    - code 1 -> NO_TILE
    - code 2 -> included, marked for clearing
    - other codes -> included
    - The center is always included.
    - Order: [5i+0]=center, +1 up, +2 down, +3 left, +4 right.
    - All five die_addr entries update on the same Clk at the end of SCAN -> BLAST.
  - BLAST: marked bricks are written with ram_addr = tile, ram_data = 0, ram_en = 1, one per Clk, starting the cycle after BLAST entry. After BLAST_FRAMES frame_ticks, die_addr[5i..5i+4] = NO_TILE -> IDLE.
- Arbitration: the read port and the write port are each shared. Slot 0 wins simultaneous requests; slot 1 stalls and does not lose requests.
- A SCAN completes in 6 Clk or fewer without contention, and 12 or fewer with contention.
- ram_en is never high for two different addresses in the same cycle, and each brick is written exactly once.
- A drop while the slot is busy is ignored; nothing is queued.

Optional Feature:
- CHAIN_BLAST_EN defined: when a slot's die_addr (after SCAN) contains the other slot's ARMED center, the other slot goes directly to SCAN on the next Clk.
- Undefined: the other bomb keeps its own fuse.

Decomposition:
- Shared package bomb_pkg holds:
  - tile-code constants and NO_TILE
  - the slot state enum typedef (IDLE, ARMED, SCAN, BLAST)
  - the MAP_COLS/MAP_ROWS defaults
  - the tile-index function
- One natural sub-module, bomb_slot: per-slot FSM, fuse/blast counters, scan capture, brick mask. The top instantiates two of them plus the frame_tick synchronizer and the read/write arbiters.

Test Plan:
- Bench uses FUSE_FRAMES=4, BLAST_FRAMES=3. user1X=100, user1Y=100, drop[0] pulsed for one frame with map all 0 -> bomb_addr[0]=63 and bomb_active[0]=1; after 4 ticks die_addr[0..4] = 63, 43, 83, 62, 64; NO_TILE again after 3 more ticks.
- Same stimulus with tile 43=1 and tile 64=2 -> die_addr[1]=3FF, die_addr[4]=64; exactly one ram_en pulse, with ram_addr=64 and ram_data=0.
- Bomb at tile 0 (X=0, Y=0) -> up and left are NO_TILE with no rd_addr access to them; down=20, right=1.
- Both players drop on the same frame_tick at distinct tiles with bricks -> slot 0 reads and writes first, slot 1 stalls; the full write set arrives with no lost or duplicate writes.
- Reset_n asserted mid-BLAST while a write is pending -> die_addr all 3FF and ram_en=0 immediately; no further writes after release.
- Slot 1 armed at tile 64, slot 0 blasts covering 64 -> with CHAIN_BLAST_EN, slot 1 reaches SCAN next Clk; without it, slot 1 waits for its own fuse.
